// File: rtl/bus_pkg.sv
// Shared definitions for the system data bus: address map, master IDs and
// the request payload carried through the arbiter holding register.
package bus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [ADDR_W-1:0] DM_BASE   = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DM_LIMIT  = 32'h0000_2FFF;
  localparam logic [ADDR_W-1:0] TM0_BASE  = 32'h0000_7F00;
  localparam logic [ADDR_W-1:0] TM0_LIMIT = 32'h0000_7F0B;
  localparam logic [ADDR_W-1:0] TM1_BASE  = 32'h0000_7F10;
  localparam logic [ADDR_W-1:0] TM1_LIMIT = 32'h0000_7F1B;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  localparam logic [BE_W-1:0] BYTEEN_READ = 4'b0000;
  localparam logic [BE_W-1:0] BYTEEN_WORD = 4'b1111;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [BE_W-1:0]   byteen;
  } bus_req_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side handshakes plus the bridge-side bus of the two-master arbiter.
interface bus_arbiter_if;
  import bus_pkg::*;

  logic              m0_req,    m1_req;
  logic [ADDR_W-1:0] m0_addr,   m1_addr;
  logic [DATA_W-1:0] m0_wd,     m1_wd;
  logic [BE_W-1:0]   m0_byteen, m1_byteen;
  logic              m0_gnt,    m1_gnt;
  logic [DATA_W-1:0] m0_rd,     m1_rd;
  logic              m0_rvalid, m1_rvalid;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wd;
  logic [BE_W-1:0]   bus_byteen;
  logic [DATA_W-1:0] bus_rd;

  // Arbiter view
  modport slave (
    input  m0_req, m0_addr, m0_wd, m0_byteen,
    input  m1_req, m1_addr, m1_wd, m1_byteen,
    output m0_gnt, m0_rd, m0_rvalid,
    output m1_gnt, m1_rd, m1_rvalid,
    output bus_addr, bus_wd, bus_byteen,
    input  bus_rd
  );

  // Masters plus bridge view
  modport master (
    output m0_req, m0_addr, m0_wd, m0_byteen,
    output m1_req, m1_addr, m1_wd, m1_byteen,
    input  m0_gnt, m0_rd, m0_rvalid,
    input  m1_gnt, m1_rd, m1_rvalid,
    input  bus_addr, bus_wd, bus_byteen,
    output bus_rd
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive refused cycles for the low-priority master;
// o_force tells the arbiter to let it win this cycle.
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_granted,
  output logic o_force
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)                    r_cnt <= '0;
    else if (!i_req || i_granted) r_cnt <= '0;
    else if (r_cnt != LIM)        r_cnt <= r_cnt + 4'd1;
  end

  assign o_force = (r_cnt == LIM);
endmodule

// File: rtl/bus_arbiter.sv
// Fixed-priority two-master bus arbiter: one holding stage toward the bridge,
// one registered response stage back to the owning master.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bif
);
  logic              w_force, w_m0_win, w_m1_win, w_bus_on;
  bus_req_t          w_m0_pl, w_m1_pl, r_hold;
  logic              r_hold_valid, r_hold_owner;
  logic              r_resp_valid, r_resp_owner;
  logic [DATA_W-1:0] r_rd;

  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .reset     (reset),
    .i_req     (bif.m1_req),
    .i_granted (w_m1_win),
    .o_force   (w_force)
  );

  always_comb begin
    w_m0_pl  = '{addr: bif.m0_addr, wd: bif.m0_wd, byteen: bif.m0_byteen};
    w_m1_pl  = '{addr: bif.m1_addr, wd: bif.m1_wd, byteen: bif.m1_byteen};
    w_m1_win = bif.m1_req && (!bif.m0_req || w_force);
    w_m0_win = bif.m0_req && !w_m1_win;
  end

  assign bif.m0_gnt = !reset && w_m0_win;
  assign bif.m1_gnt = !reset && w_m1_win;

  // Payload is cleared on idle cycles so the bus reads as all-zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_owner <= MST_CPU;
      r_hold       <= '0;
    end else begin
      r_hold_valid <= w_m0_win || w_m1_win;
      r_hold_owner <= w_m1_win ? MST_DMA : MST_CPU;
      r_hold       <= w_m1_win ? w_m1_pl : (w_m0_win ? w_m0_pl : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_owner <= MST_CPU;
      r_rd         <= '0;
    end else if (r_hold_valid) begin
      r_resp_valid <= (r_hold.byteen == BYTEEN_READ);
      r_resp_owner <= r_hold_owner;
      r_rd         <= bif.bus_rd;
    end else begin
      r_resp_valid <= 1'b0;
    end
  end

  // Gating by reset keeps a just-latched write off the bus in the reset cycle.
  assign w_bus_on       = r_hold_valid && !reset;
  assign bif.bus_addr   = w_bus_on ? r_hold.addr   : '0;
  assign bif.bus_wd     = w_bus_on ? r_hold.wd     : '0;
  assign bif.bus_byteen = w_bus_on ? r_hold.byteen : BYTEEN_READ;

  assign bif.m0_rvalid = !reset && r_resp_valid && (r_resp_owner == MST_CPU);
  assign bif.m1_rvalid = !reset && r_resp_valid && (r_resp_owner == MST_DMA);
  assign bif.m0_rd     = r_rd;
  assign bif.m1_rd     = r_rd;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant/bus checks inline, read responses
// scored against a queue of expected {owner, data, cycle} entries.
module tb_bus_arbiter;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_arbiter_if bif();
  bus_arbiter #(.STARVE_LIMIT(4)) u_dut (.clk(clk), .reset(reset), .bif(bif));

  // Bridge model: fixed read data per address
  function automatic logic [31:0] rd_of(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'hDEAD_BEEF;
      32'h0000_0200: return 32'h1234_5678;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction
  assign bif.bus_rd = rd_of(bif.bus_addr);

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;
  exp_t q[$];

  int n_tests = 0, n_fail = 0;
  logic [31:0] cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push(input logic owner, input logic [31:0] a);
    q.push_back('{owner: owner, data: rd_of(a), due: cyc_n + 2});
  endtask

  task automatic m0_set(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bif.m0_req = r; bif.m0_addr = a; bif.m0_wd = d; bif.m0_byteen = be;
  endtask

  task automatic m1_set(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bif.m1_req = r; bif.m1_addr = a; bif.m1_wd = d; bif.m1_byteen = be;
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (bif.m0_rvalid && bif.m1_rvalid) begin
      n_tests++; n_fail++;
      $display("FAIL both_rvalid: both masters got rvalid at cycle %0d", cyc_n);
    end else if (bif.m0_rvalid || bif.m1_rvalid) begin
      logic [31:0] act;
      exp_t e;
      act = bif.m1_rvalid ? bif.m1_rd : bif.m0_rd;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rvalid: owner %0d data %h at cycle %0d, none expected",
                 bif.m1_rvalid, act, cyc_n);
      end else begin
        e = q.pop_front();
        if (e.owner !== bif.m1_rvalid || e.data !== act || e.due != cyc_n) begin
          n_fail++;
          $display("FAIL rvalid: got owner %0d data %h cycle %0d expected owner %0d data %h cycle %0d",
                   bif.m1_rvalid, act, cyc_n, e.owner, e.data, e.due);
        end
      end
    end
  end

  logic [31:0] m0a, m1a;
  logic        exp1;
  logic [3:0]  be_t [3];

  initial begin
    be_t[0] = 4'b0011; be_t[1] = 4'b1111; be_t[2] = 4'b1100;
    reset = 1'b1;
    m0_set(1'b1, 32'h10, 32'h0, 4'h0);
    m1_set(1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) nxt();

    // Reset state: grants forced low, bus idle, no responses
    neg();
    chk("rst_m0_gnt", {31'd0, bif.m0_gnt}, 32'd0);
    chk("rst_bus_byteen", {28'd0, bif.bus_byteen}, 32'd0);
    chk("rst_bus_addr", bif.bus_addr, 32'd0);
    chk("rst_m0_rd", bif.m0_rd, 32'd0);
    chk("rst_rvalid", {30'd0, bif.m0_rvalid, bif.m1_rvalid}, 32'd0);

    // Single m0 read
    nxt(); reset = 1'b0;
    m0_set(1'b1, 32'h10, 32'h0, BYTEEN_READ);
    neg();
    chk("rd_m0_gnt", {31'd0, bif.m0_gnt}, 32'd1);
    chk("rd_m1_gnt", {31'd0, bif.m1_gnt}, 32'd0);
    push(MST_CPU, 32'h10);
    nxt(); bif.m0_req = 1'b0;
    neg();
    chk("rd_bus_addr", bif.bus_addr, 32'h10);
    chk("rd_bus_byteen", {28'd0, bif.bus_byteen}, 32'd0);
    nxt();

    // Back-to-back m0 write then m1 read
    m0_set(1'b1, 32'h7F00, 32'h9, BYTEEN_WORD);
    neg();
    chk("b2b_m0_gnt", {31'd0, bif.m0_gnt}, 32'd1);
    nxt(); bif.m0_req = 1'b0;
    m1_set(1'b1, 32'h200, 32'h0, BYTEEN_READ);
    neg();
    chk("b2b_m1_gnt", {31'd0, bif.m1_gnt}, 32'd1);
    chk("b2b_wr_addr", bif.bus_addr, 32'h7F00);
    chk("b2b_wr_wd", bif.bus_wd, 32'h9);
    chk("b2b_wr_be", {28'd0, bif.bus_byteen}, 32'hF);
    push(MST_DMA, 32'h200);
    nxt(); bif.m1_req = 1'b0;
    neg();
    chk("b2b_rd_addr", bif.bus_addr, 32'h200);
    chk("b2b_rd_be", {28'd0, bif.bus_byteen}, 32'd0);
    nxt();

    // Contention: m1 forced through every fifth cycle
    m0a = 32'h100; m1a = 32'h300;
    for (int k = 0; k < 10; k++) begin
      m0_set(1'b1, m0a, 32'h0, BYTEEN_READ);
      m1_set(1'b1, m1a, 32'h0, BYTEEN_READ);
      neg();
      exp1 = (k == 4) || (k == 9);
      chk($sformatf("cont_m0_gnt_%0d", k), {31'd0, bif.m0_gnt}, {31'd0, !exp1});
      chk($sformatf("cont_m1_gnt_%0d", k), {31'd0, bif.m1_gnt}, {31'd0, exp1});
      if (exp1) begin push(MST_DMA, m1a); m1a += 4; end
      else      begin push(MST_CPU, m0a); m0a += 4; end
      nxt();
    end
    bif.m0_req = 1'b0; bif.m1_req = 1'b0;
    nxt();

    // m1 alone, three writes
    for (int k = 0; k < 3; k++) begin
      m1_set(1'b1, 32'h2000 + 32'(4 * k), 32'(k + 1), be_t[k]);
      neg();
      chk($sformatf("solo_m1_gnt_%0d", k), {31'd0, bif.m1_gnt}, 32'd1);
      chk($sformatf("solo_m0_gnt_%0d", k), {31'd0, bif.m0_gnt}, 32'd0);
      if (k > 0) chk($sformatf("solo_be_%0d", k - 1), {28'd0, bif.bus_byteen}, {28'd0, be_t[k - 1]});
      nxt();
    end
    bif.m1_req = 1'b0;
    neg();
    chk("solo_last_addr", bif.bus_addr, 32'h2008);
    chk("solo_last_be", {28'd0, bif.bus_byteen}, {28'd0, be_t[2]});
    nxt();
    neg();
    chk("solo_idle_be", {28'd0, bif.bus_byteen}, 32'd0);
    chk("solo_idle_addr", bif.bus_addr, 32'd0);
    chk("solo_idle_wd", bif.bus_wd, 32'd0);
    nxt();

    // Reset with a read and a write in flight
    m1_set(1'b1, 32'h20, 32'h0, BYTEEN_READ);
    neg();
    chk("mid_m1_gnt", {31'd0, bif.m1_gnt}, 32'd1);
    nxt(); bif.m1_req = 1'b0;
    m0_set(1'b1, 32'h4, 32'h55, BYTEEN_WORD);
    neg();
    chk("mid_m0_gnt", {31'd0, bif.m0_gnt}, 32'd1);
    chk("mid_rd_addr", bif.bus_addr, 32'h20);
    nxt(); reset = 1'b1;
    m0_set(1'b1, 32'h8, 32'h0, BYTEEN_READ);
    neg();
    chk("rst_wr_be", {28'd0, bif.bus_byteen}, 32'd0);
    chk("rst_wr_addr", bif.bus_addr, 32'd0);
    chk("rst_wr_wd", bif.bus_wd, 32'd0);
    chk("rst_gnt", {30'd0, bif.m0_gnt, bif.m1_gnt}, 32'd0);
    nxt();
    neg();
    chk("rst2_be", {28'd0, bif.bus_byteen}, 32'd0);
    chk("rst2_rd", bif.m0_rd, 32'd0);
    chk("rst2_rvalid", {30'd0, bif.m0_rvalid, bif.m1_rvalid}, 32'd0);
    nxt(); reset = 1'b0;
    neg();
    chk("post_m0_gnt", {31'd0, bif.m0_gnt}, 32'd1);
    push(MST_CPU, 32'h8);
    nxt(); bif.m0_req = 1'b0;
    neg();
    chk("post_bus_addr", bif.bus_addr, 32'h8);
    repeat (4) nxt();

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_rvalid: %0d responses never arrived, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
